// File: rtl/ntt_carry_resolve.sv
// Carry resolver for NTT convolution output: folds each coefficient plus the running carry
// into one radix-2^DIGW digit, then flushes the residual carry after the last coefficient.
module ntt_carry_resolve #(
   parameter int COEFW = 32,
   parameter int DIGW  = 8,
   parameter int CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [COEFW-1:0] in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [DIGW-1:0]  out_digit_o,
   output logic             out_last_o,
   output logic [CNTW-1:0]  digit_count_o,
   output logic             done_o
);

   localparam int CARW = COEFW - DIGW + 1;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CARW-1:0]   carry_q, carry_d;
   logic              ov_q, ov_d;
   logic [DIGW-1:0]   digit_q, digit_d;
   logic              olast_q, olast_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              first_q, first_d;

   logic              free_s, out_hs_s, last_pend_s, in_xfer_s;
   logic [COEFW:0]    acc_s;
   logic [CARW-1:0]   acc_carry_s, flush_carry_s;

   assign free_s        = !ov_q || out_ready_i;
   assign out_hs_s      = ov_q && out_ready_i;
   assign last_pend_s   = ov_q && olast_q;
   assign in_xfer_s     = in_valid_i && in_ready_o;
   assign acc_s         = {1'b0, in_data_i} + {{DIGW{1'b0}}, carry_q};
   assign acc_carry_s   = acc_s[COEFW:DIGW];
   assign flush_carry_s = carry_q >> DIGW;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (in_xfer_s && in_last_i && (acc_carry_s != {CARW{1'b0}})) begin
               state_d = S_FLUSH;
            end else if (last_pend_s && out_ready_i) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            if (last_pend_s && out_ready_i) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FLUSH;
            end
         end
         S_DONE:  state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   // FSM outputs; once the final digit is loaded no further beat may enter the frame
   always_comb begin
      in_ready_o = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         S_RUN:   in_ready_o = !rst && free_s && !last_pend_s;
         S_FLUSH: in_ready_o = 1'b0;
         S_DONE:  done_o     = 1'b1;
         default: in_ready_o = 1'b0;
      endcase
   end

   // Datapath next-state: digit register, carry, counter, new-frame flag
   always_comb begin
      carry_d = carry_q;
      ov_d    = ov_q && !out_ready_i;
      digit_d = digit_q;
      olast_d = olast_q;
      cnt_d   = cnt_q + CNTW'(out_hs_s);
      first_d = first_q;
      if (in_xfer_s) begin
         ov_d    = 1'b1;
         digit_d = acc_s[DIGW-1:0];
         carry_d = acc_carry_s;
         olast_d = in_last_i && (acc_carry_s == {CARW{1'b0}});
         first_d = 1'b0;
         if (first_q) begin
            cnt_d = CNTW'(out_hs_s);
         end else begin
            cnt_d = cnt_q + CNTW'(out_hs_s);
         end
      end else if ((state_q == S_FLUSH) && free_s && !last_pend_s) begin
         ov_d    = 1'b1;
         digit_d = carry_q[DIGW-1:0];
         carry_d = flush_carry_s;
         olast_d = (flush_carry_s == {CARW{1'b0}});
      end else if (state_q == S_DONE) begin
         carry_d = {CARW{1'b0}};
         first_d = 1'b1;
      end else begin
         first_d = first_q;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= {CARW{1'b0}};
         ov_q    <= 1'b0;
         digit_q <= {DIGW{1'b0}};
         olast_q <= 1'b0;
         cnt_q   <= {CNTW{1'b0}};
         first_q <= 1'b1;
      end else begin
         carry_q <= carry_d;
         ov_q    <= ov_d;
         digit_q <= digit_d;
         olast_q <= olast_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
      end
   end

   assign out_valid_o   = ov_q;
   assign out_digit_o   = digit_q;
   assign out_last_o    = olast_q;
   assign digit_count_o = cnt_q;

endmodule

// File: tb/tb_ntt_carry_resolve.sv
// Bench for ntt_carry_resolve: each frame's digits are the base-256 expansion of
// sum(c[i] * 256^i), checked against hand-computed literals and against the DUT every cycle.
module tb_ntt_carry_resolve;
   localparam int COEFW = 32;
   localparam int DIGW  = 8;
   localparam int CNTW  = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [COEFW-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [DIGW-1:0]  out_digit;
   logic             out_last;
   logic [CNTW-1:0]  digit_count;
   logic             done;

   ntt_carry_resolve #(.COEFW(COEFW), .DIGW(DIGW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_digit_o(out_digit),
      .out_last_o(out_last), .digit_count_o(digit_count), .done_o(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } dig_t;

   int         n_vec = 0;
   int         n_bad = 0;
   dig_t       exp_q[$];
   dig_t       pop_e;
   logic       exp_done = 1'b0;
   logic [31:0] cf[4];
   int         ncf;
   logic [7:0] lit[8];
   int         nlit;
   int         exp_len;

   function automatic void chk(string name, longint act, longint req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endfunction

   // Reference: digits of the whole frame value, at least one per coefficient
   task automatic build_expect();
      longint unsigned v = 0;
      dig_t md[$];
      dig_t e;
      int k = 0;
      for (int i = 0; i < ncf; i++) v += longint'(cf[i]) << (8 * i);
      while (k < ncf || (v >> (8 * k)) != 0) begin
         e.d = 8'((v >> (8 * k)) & 64'hFF);
         e.l = 1'b0;
         md.push_back(e);
         k++;
      end
      md[md.size() - 1].l = 1'b1;
      chk("model_len", md.size(), nlit);
      for (int i = 0; i < md.size() && i < nlit; i++) chk("model_digit", md[i].d, lit[i]);
      foreach (md[i]) exp_q.push_back(md[i]);
      exp_len = md.size();
   endtask

   task automatic push(input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      chk("in_accept", ok, 1);
   endtask

   task automatic wait_done(input int cnt_exp);
      bit seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", seen, 1);
      chk("digit_count", digit_count, cnt_exp);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   task automatic run_frame();
      build_expect();
      for (int i = 0; i < ncf; i++) push(cf[i], i == ncf - 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      wait_done(exp_len);
   endtask

   task automatic check_reset_state();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_digit", out_digit, 0);
      chk("rst_digit_count", digit_count, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready_after", in_ready, 1);
   endtask

   // Every-cycle scoreboard: digits in order, done exactly one cycle after the last handshake
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_done <= 1'b0;
      end else begin
         chk("done_pulse", done, exp_done);
         exp_done <= 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_digit", out_digit, 0);
               n_bad += (out_digit == 8'd0) ? 1 : 0;
            end else begin
               pop_e = exp_q.pop_front();
               chk("out_digit", out_digit, pop_e.d);
               chk("out_last", out_last, pop_e.l);
               if (pop_e.l) exp_done <= 1'b1;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("in_ready_in_reset", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(posedge clk); #1;

      // 300, 5(last) -> 2C, 06
      cf[0] = 32'd300; cf[1] = 32'd5; ncf = 2;
      lit[0] = 8'h2C; lit[1] = 8'h06; nlit = 2;
      run_frame();

      // 0x1FFFF(last) -> FF, FF, 01 via flush
      cf[0] = 32'h1FFFF; ncf = 1;
      lit[0] = 8'hFF; lit[1] = 8'hFF; lit[2] = 8'h01; nlit = 3;
      run_frame();

      // 255, 255(last) -> FF, FF, no flush
      cf[0] = 32'd255; cf[1] = 32'd255; ncf = 2;
      lit[0] = 8'hFF; lit[1] = 8'hFF; nlit = 2;
      run_frame();

      // all-zero stream keeps one digit per coefficient
      cf[0] = 32'd0; cf[1] = 32'd0; cf[2] = 32'd0; ncf = 3;
      lit[0] = 8'h00; lit[1] = 8'h00; lit[2] = 8'h00; nlit = 3;
      run_frame();

      // maximum coefficients: longest flush
      cf[0] = 32'hFFFFFFFF; cf[1] = 32'hFFFFFFFF; ncf = 2;
      lit[0] = 8'hFF; lit[1] = 8'hFE; lit[2] = 8'hFF; lit[3] = 8'hFF;
      lit[4] = 8'h00; lit[5] = 8'h01; nlit = 6;
      run_frame();

      // 300, 5(last) with a 3-cycle stall after the first digit
      cf[0] = 32'd300; cf[1] = 32'd5; ncf = 2;
      lit[0] = 8'h2C; lit[1] = 8'h06; nlit = 2;
      build_expect();
      push(32'd300, 1'b0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'd5; in_last = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_digit", out_digit, 8'h2C);
         chk("stall_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      push(32'd5, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      wait_done(exp_len);

      // reset during flush aborts the frame
      push(32'h1FFFF, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("in_ready_in_reset2", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state();
      @(posedge clk); #1;
      cf[0] = 32'd7; ncf = 1;
      lit[0] = 8'h07; nlit = 1;
      run_frame();

      // back-to-back single-coefficient frames with valid held high
      cf[0] = 32'd1; ncf = 1; lit[0] = 8'h01; nlit = 1;
      build_expect();
      cf[0] = 32'd2; lit[0] = 8'h02;
      build_expect();
      push(32'd1, 1'b1);
      push(32'd2, 1'b1);
      in_valid = 1'b0; in_last = 1'b0;
      wait_done(1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ntt_carry_resolve.md
NTT_CARRY_RESOLVE -- requirements
Module: ntt_carry_resolve

Interface
REQ-001 Parameter COEFW, default 32, width of the convolution coefficients received from the NTT multiplier (normalized, < 2^COEFW).
REQ-002 Parameter DIGW, default 8, output digit width; the output radix is 2^DIGW; DIGW < COEFW.
REQ-003 Parameter CNTW, default 16, width of the digit counter.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  coefficient present on in_data.
REQ-007 in_ready  output  1  block accepts a coefficient this cycle.
REQ-008 in_data  input  COEFW  convolution coefficient, lowest index first.
REQ-009 in_last  input  1  marks the final coefficient of a frame.
REQ-010 out_valid  output  1  digit present on out_digit.
REQ-011 out_ready  input  1  downstream accepts the digit.
REQ-012 out_digit  output  DIGW  radix-2^DIGW digit, least significant first.
REQ-013 out_last  output  1  marks the final digit of a frame; qualified by out_valid.
REQ-014 digit_count  output  CNTW  digits emitted in the current or most recent frame.
REQ-015 done  output  1  one-cycle pulse on the cycle after the out_last handshake.

Function
REQ-016 A transfer occurs on a cycle where valid and ready are both high; the same rule applies on both ports.
REQ-017 The FSM has three states: RUN (accept coefficients), FLUSH (emit residual carry), and DONE (one cycle, asserts done).
REQ-018 In RUN, in_ready = !out_valid || out_ready; in FLUSH and DONE, in_ready = 0.
REQ-019 On an input transfer: acc = in_data + carry, computed in COEFW+1 bits with no truncation.
REQ-020 On the same input transfer, the output register loads acc[DIGW-1:0] and carry is updated to acc >> DIGW.
REQ-021 Input-to-output latency is 1 cycle: out_valid rises on the edge after the input transfer.
REQ-022 When in_last is transferred and the new carry is 0: out_last = 1 on that digit, and the FSM stays in RUN until that digit's handshake, then goes to DONE.
REQ-023 When in_last is transferred and the new carry is nonzero: the FSM goes to FLUSH.
REQ-024 In FLUSH, whenever the output register is free (see REQ-026), it loads carry[DIGW-1:0] and carry is updated to carry >> DIGW.
REQ-025 In FLUSH, out_last is set on the load that leaves carry = 0; after that digit's handshake the FSM goes to DONE.
REQ-026 The output register is free when !out_valid || out_ready; a new digit may load on the same cycle the previous digit handshakes, giving a throughput of 1 digit/cycle.
REQ-027 While out_valid = 1 and out_ready = 0, out_digit and out_last are held stable; no input is accepted and carry does not change.
REQ-028 digit_count increments on each output handshake; it clears on the first input transfer of a new frame, not at the end of a frame.
REQ-029 DONE lasts one cycle with done = 1, then returns to RUN with carry = 0.
REQ-030 An all-zero coefficient stream still emits one digit per coefficient; leading zero digits are not trimmed.
REQ-031 A single-coefficient frame (in_valid with in_last on the first beat) is legal.
REQ-032 Maximum residual carry is < 2^(COEFW-DIGW+1); FLUSH therefore emits at most ceil((COEFW-DIGW+1)/DIGW) digits.
REQ-033 The input beat after in_last is not accepted until DONE has completed, so frames never overlap.

Reset
REQ-034 On rst: state = RUN, carry = 0, out_valid = 0, out_last = 0, out_digit = 0, digit_count = 0, done = 0.
REQ-035 rst asserted mid-frame or mid-FLUSH aborts the frame; the pending digit and carry are discarded and no done pulse is produced.
REQ-036 rst has priority over any simultaneous handshake.
REQ-037 in_ready = 0 on the reset cycle.

Verification (DIGW=8, COEFW=32)
REQ-038 Inputs 300, 5(last), out_ready=1 -> digits 0x2C, 0x06 (out_last on 0x06); digit_count = 2; done pulses once.
REQ-039 Input 0x1FFFF(last) -> digits 0xFF, 0xFF, 0x01 (last); FLUSH entered; digit_count = 3.
REQ-040 Inputs 255, 255(last) -> digits 0xFF, 0xFF(last); carry stays 0 throughout; no FLUSH.
REQ-041 Inputs 300, 5(last) with out_ready held low for 3 cycles after the first digit -> 0x2C held stable and in_ready = 0 during the stall; the sequence then completes identically to REQ-038.
REQ-042 Input 0x1FFFF(last), rst asserted during FLUSH -> all outputs at reset values the next cycle, no done pulse; a following frame 7(last) -> single digit 0x07(last), digit_count = 1.
REQ-043 Back-to-back frames 1(last), 2(last) with continuous valid -> digits 0x01(last), done, 0x02(last), done; digit_count resets to 1 for the second frame.
